// File: rtl/regfile_dump.sv
// Debug read-out sequencer: walks a wrapping register range through one regfile
// read port and streams (address, data) beats on a valid/ready interface.
//   state | meaning
//   IDLE  | waiting for i_start; o_rs_addr holds its last value
//   LOAD  | o_rs_addr presented to the regfile; capture data at the edge
//   SEND  | beat held on o_valid until accepted
//   DONE  | one-cycle o_done pulse after the final accept
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_rs_addr,
  input  logic [DATA_W-1:0] i_rs_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] last_addr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (i_ready) state_nxt = o_last ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are flops loaded from the next state so every output is registered.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_valid <= (state_nxt == SEND);
      o_busy  <= (state_nxt != IDLE);
      o_done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rs_addr <= '0;
      last_addr <= '0;
      o_data    <= '0;
      o_addr    <= '0;
      o_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            last_addr <= i_last_addr;
            o_rs_addr <= i_first_addr;
          end
        end
        LOAD: begin
          o_data <= i_rs_data;
          o_addr <= o_rs_addr;
          o_last <= (o_rs_addr == last_addr);
        end
        SEND: begin
          // Natural ADDR_W-bit overflow gives the 31 -> 0 wrap.
          if (i_ready && !o_last) o_rs_addr <= o_rs_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out sequencer for the integer register file. On a start request it walks a contiguous, possibly wrapping, range of register addresses through one regfile read port. It captures each 32-bit value and streams it out as (address, data) beats on a valid/ready interface toward the debug/UART path. It is the reading end of the regfile port and sits beside the core; the core is not stalled.

## Interface

- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)

- i_clk  input  1  clock; all state updates on rising edge
- i_reset  input  1  reset, asynchronous, active-high
- i_start  input  1  request a dump; sampled only in IDLE
- i_first_addr  input  ADDR_W  first register of range; sampled with i_start
- i_last_addr  input  ADDR_W  last register of range; sampled with i_start
- o_rs_addr  output  ADDR_W  address driven to a regfile read port
- i_rs_data  input  DATA_W  combinational read data returned for o_rs_addr
- o_valid  output  1  beat available
- i_ready  input  1  downstream accepts beat when o_valid && i_ready
- o_data  output  DATA_W  captured register value
- o_addr  output  ADDR_W  register index of o_data
- o_last  output  1  beat is the final one of the dump
- o_busy  output  1  dump in progress (not IDLE)
- o_done  output  1  one-cycle pulse after the final beat is accepted

## Operation

- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE: o_busy=0, o_valid=0. If i_start=1, latch i_last_addr, set o_rs_addr<=i_first_addr, and go to LOAD.
- LOAD: o_busy=1. At the clock edge, capture o_data<=i_rs_data, o_addr<=o_rs_addr, and o_last<=(o_rs_addr==latched last). Go to SEND.
- SEND: o_valid=1. o_data, o_addr and o_last are held stable while i_ready=0.
  - On accept with o_last=0: o_rs_addr<=o_rs_addr+1 (mod 32, so 31 wraps to 0), then go to LOAD.
  - On accept with o_last=1: go to DONE.
- DONE: o_done=1 for exactly this cycle, o_valid=0, o_busy=1; next state IDLE.
- Range rules:
  - first==last produces exactly one beat.
  - first>last wraps through 31→0. Example: 30..1 yields 30,31,0,1.
  - The beat count is always ((last−first) mod 32)+1, between 1 and 32 inclusive.
- i_start outside IDLE is ignored; it is not queued.
- Snapshot semantics: each value is the regfile content as read combinationally during its LOAD cycle. A core write to the same register committing at the edge ending LOAD is not reflected. Later writes to already-captured registers are not reflected.
- o_rs_addr holds its last value in IDLE and DONE.
- x0 is dumped like any other register; the regfile guarantees it reads 0.

## Timing

- Reset (asynchronous, any state): state→IDLE. Outputs become o_rs_addr=0, o_valid=0, o_data=0, o_addr=0, o_last=0, o_busy=0, o_done=0, and the latched last address is 0.
- Reset mid-dump aborts the dump with no o_done. The next i_start after reset release starts a fresh dump.
- Start latency: i_start is sampled at edge 0 in IDLE. LOAD occupies cycle 1. o_valid first rises in cycle 2.
- Throughput: one beat per 2 cycles when i_ready=1, plus 1 cycle per cycle of i_ready=0 in SEND.
- Full 32-register dump with i_ready tied high: 64 cycles from the start edge to the last accept. o_done follows in the next cycle. The earliest next i_start is accepted on the edge ending DONE+1, i.e. in IDLE.
- o_valid never drops without an accept. No beat is emitted twice. No address is skipped.
- All outputs are registered; there is no combinational path from i_ready to any output.

## Test plan

- Full dump: preload reg[i]=32'h0000_0100+i (x0=0), first=0, last=31, i_ready=1 → 32 beats with addr 0..31 and data 0,0x101..0x11F; o_last only on addr 31; o_valid first high at cycle 2; o_done at cycle 65.
- Backpressure: first=3, last=5, i_ready low for 4 cycles on each beat → o_data/o_addr stay stable while stalled; exactly 3 beats (3,4,5) with the correct data; one o_done pulse.
- Wrap and single: first=30, last=1 → beats 30,31,0,1 with o_last on 1. Then first=last=7 → exactly one beat, addr 7, o_last=1.
- Start while busy: pulse i_start with different addresses during SEND of a 0..3 dump → ignored; the dump completes 0..3 unchanged.
- Reset mid-dump: assert i_reset during the SEND of beat 2 of a 0..31 dump → all outputs 0 immediately (asynchronously), no o_done; after release, a new start of 4..4 gives a single correct beat.
- Write collision: the core writes reg[5]=0xDEAD_BEEF at the edge ending LOAD of addr 5 (old value 0x105) → the beat reports 0x105; a dump issued afterwards reports 0xDEAD_BEEF.
